// File: rtl/sal_bank_timer.sv
// Per-bank DDR2 timing tracker: follows bank state and the open row, and only
// lets a scheduler command through once every bank-local timing window has expired.
module sal_bank_timer #(
    parameter int CNT_W = 8,
    parameter int ROW_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] t_rcd_m1,
    input  logic [CNT_W-1:0] t_rp_m1,
    input  logic [CNT_W-1:0] t_ras_m1,
    input  logic [CNT_W-1:0] t_rfc_m1,
    input  logic [CNT_W-1:0] t_rtp_m1,
    input  logic [CNT_W-1:0] t_wtp_m1,
    input  logic             req_valid,
    input  logic [2:0]       req_cmd,
    input  logic [ROW_W-1:0] req_ra,
    output logic             req_ready,
    output logic             bank_open,
    output logic [ROW_W-1:0] open_row,
    output logic             row_hit
);

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'd0,
        ST_ACTIVATING  = 3'd1,
        ST_OPEN        = 3'd2,
        ST_PRECHARGING = 3'd3,
        ST_REFRESHING  = 3'd4
    } state_t;

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    // Load on accept, otherwise count down and stick at zero.
    function automatic logic [CNT_W-1:0] cnt_next(input logic load,
                                                  input logic [CNT_W-1:0] load_val,
                                                  input logic [CNT_W-1:0] cur);
        logic [CNT_W-1:0] res;
        if (load) begin
            res = load_val;
        end else if (cur != {CNT_W{1'b0}}) begin
            res = cur - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = {CNT_W{1'b0}};
        end
        return res;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] rcd_cnt_r, ras_cnt_r, rtp_cnt_r, wtp_cnt_r, rp_cnt_r, rfc_cnt_r;
    logic [ROW_W-1:0] open_row_r;
    logic             bank_open_r;

    logic is_act_s, is_rd_s, is_wr_s, is_pre_s, is_ref_s;
    logic rcd_zero_s, ras_zero_s, rtp_zero_s, wtp_zero_s, rp_zero_s, rfc_zero_s;
    logic accept_s;

    assign is_act_s = (req_cmd == CMD_ACT);
    assign is_rd_s  = (req_cmd == CMD_RD);
    assign is_wr_s  = (req_cmd == CMD_WR);
    assign is_pre_s = (req_cmd == CMD_PRE);
    assign is_ref_s = (req_cmd == CMD_REF);

    assign rcd_zero_s = (rcd_cnt_r == {CNT_W{1'b0}});
    assign ras_zero_s = (ras_cnt_r == {CNT_W{1'b0}});
    assign rtp_zero_s = (rtp_cnt_r == {CNT_W{1'b0}});
    assign wtp_zero_s = (wtp_cnt_r == {CNT_W{1'b0}});
    assign rp_zero_s  = (rp_cnt_r  == {CNT_W{1'b0}});
    assign rfc_zero_s = (rfc_cnt_r == {CNT_W{1'b0}});

    // Command admission by current state; illegal opcodes never match.
    always_comb begin
        req_ready = 1'b0;
        case (state_r)
            ST_CLOSED:      req_ready = is_act_s | is_ref_s;
            ST_PRECHARGING: req_ready = (is_act_s | is_ref_s) & rp_zero_s;
            ST_REFRESHING:  req_ready = (is_act_s | is_ref_s) & rfc_zero_s;
            ST_ACTIVATING:  req_ready = (is_rd_s | is_wr_s) & rcd_zero_s;
            ST_OPEN:        req_ready = is_rd_s | is_wr_s |
                                        (is_pre_s & ras_zero_s & rtp_zero_s & wtp_zero_s);
            default:        req_ready = 1'b0;
        endcase
    end

    assign accept_s = req_valid & req_ready;

    // Next state: an accepted command wins over the timer-driven transitions.
    always_comb begin
        state_s = state_r;
        if (accept_s) begin
            case (req_cmd)
                CMD_ACT: state_s = ST_ACTIVATING;
                CMD_RD:  state_s = ST_OPEN;
                CMD_WR:  state_s = ST_OPEN;
                CMD_PRE: state_s = ST_PRECHARGING;
                CMD_REF: state_s = ST_REFRESHING;
                default: state_s = state_r;
            endcase
        end else begin
            case (state_r)
                ST_ACTIVATING:  state_s = rcd_zero_s ? ST_OPEN   : ST_ACTIVATING;
                ST_PRECHARGING: state_s = rp_zero_s  ? ST_CLOSED : ST_PRECHARGING;
                ST_REFRESHING:  state_s = rfc_zero_s ? ST_CLOSED : ST_REFRESHING;
                default:        state_s = state_r;
            endcase
        end
    end

    // State, timing counters, open row and registered bank_open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CLOSED;
            rcd_cnt_r   <= {CNT_W{1'b0}};
            ras_cnt_r   <= {CNT_W{1'b0}};
            rtp_cnt_r   <= {CNT_W{1'b0}};
            wtp_cnt_r   <= {CNT_W{1'b0}};
            rp_cnt_r    <= {CNT_W{1'b0}};
            rfc_cnt_r   <= {CNT_W{1'b0}};
            open_row_r  <= {ROW_W{1'b0}};
            bank_open_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            rcd_cnt_r   <= cnt_next(accept_s & is_act_s, t_rcd_m1, rcd_cnt_r);
            ras_cnt_r   <= cnt_next(accept_s & is_act_s, t_ras_m1, ras_cnt_r);
            rtp_cnt_r   <= cnt_next(accept_s & is_rd_s,  t_rtp_m1, rtp_cnt_r);
            wtp_cnt_r   <= cnt_next(accept_s & is_wr_s,  t_wtp_m1, wtp_cnt_r);
            rp_cnt_r    <= cnt_next(accept_s & is_pre_s, t_rp_m1,  rp_cnt_r);
            rfc_cnt_r   <= cnt_next(accept_s & is_ref_s, t_rfc_m1, rfc_cnt_r);
            open_row_r  <= (accept_s & is_act_s) ? req_ra : open_row_r;
            bank_open_r <= (state_s == ST_ACTIVATING) | (state_s == ST_OPEN);
        end
    end

    assign bank_open = bank_open_r;
    assign open_row  = open_row_r;
    assign row_hit   = bank_open_r & (req_ra == open_row_r);

endmodule

// File: tb/tb_sal_bank_timer.sv
// Scoreboard bench for sal_bank_timer: a timestamp-based bank model predicts each
// cycle's outputs, a separate monitor pops the predictions and compares them.
module tb_sal_bank_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  t_rcd_m1 = 8'd0, t_rp_m1 = 8'd0, t_ras_m1 = 8'd0;
    logic [7:0]  t_rfc_m1 = 8'd0, t_rtp_m1 = 8'd0, t_wtp_m1 = 8'd0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_cmd = 3'd0;
    logic [13:0] req_ra = 14'd0;
    logic        req_ready, bank_open, row_hit;
    logic [13:0] open_row;

    sal_bank_timer #(.CNT_W(8), .ROW_W(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1),
        .t_rfc_m1(t_rfc_m1), .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ra(req_ra),
        .req_ready(req_ready), .bank_open(bank_open), .open_row(open_row), .row_hit(row_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        open;
        logic        hit;
        logic [13:0] row;
        longint      cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   drv_done = 1'b0;

    // Bank model: remembers when each command was last accepted and with which timing.
    longint      cyc = 0;
    int          last_c;
    longint      act_t, rd_t, wr_t, pre_t, ref_t;
    int          c_rcd, c_ras, c_rtp, c_wtp, c_rp, c_rfc;
    logic [13:0] m_row;
    logic [7:0]  n_rcd = 8'd0, n_rp = 8'd0, n_ras = 8'd0, n_rfc = 8'd0, n_rtp = 8'd0, n_wtp = 8'd0;

    function automatic void m_reset();
        last_c = 0;
        act_t = -1000; rd_t = -1000; wr_t = -1000; pre_t = -1000; ref_t = -1000;
        c_rcd = 0; c_ras = 0; c_rtp = 0; c_wtp = 0; c_rp = 0; c_rfc = 0;
        m_row = 14'd0;
    endfunction

    function automatic bit m_open();
        return (last_c == 1) || (last_c == 2) || (last_c == 3);
    endfunction

    function automatic bit m_ready(input logic [2:0] c);
        bit act_ref = (c == 3'd1) || (c == 3'd5);
        bit past_rcd;
        case (last_c)
            0: return act_ref;
            4: return act_ref && (cyc >= pre_t + c_rp + 1);
            5: return act_ref && (cyc >= ref_t + c_rfc + 1);
            default: begin
                // The bank only reaches OPEN (where PRE is legal) one cycle after tRCD has elapsed
                // unless a RD/WR got there first.
                past_rcd = (last_c != 1) || (cyc >= act_t + c_rcd + 2);
                if (c == 3'd2 || c == 3'd3) return cyc >= act_t + c_rcd + 1;
                if (c == 3'd4) return past_rcd && (cyc >= act_t + c_ras + 1) &&
                                      (cyc >= rd_t + c_rtp + 1) && (cyc >= wr_t + c_wtp + 1);
                return 1'b0;
            end
        endcase
    endfunction

    function automatic void m_accept(input logic [2:0] c, input logic [13:0] ra);
        case (c)
            3'd1: begin act_t = cyc; c_rcd = int'(t_rcd_m1); c_ras = int'(t_ras_m1); m_row = ra; end
            3'd2: begin rd_t = cyc; c_rtp = int'(t_rtp_m1); end
            3'd3: begin wr_t = cyc; c_wtp = int'(t_wtp_m1); end
            3'd4: begin pre_t = cyc; c_rp = int'(t_rp_m1); end
            3'd5: begin ref_t = cyc; c_rfc = int'(t_rfc_m1); end
            default: ;
        endcase
        last_c = int'(c);
    endfunction

    function automatic void push_exp(input logic [2:0] c, input logic [13:0] ra);
        exp_t e;
        e.ready = m_ready(c);
        e.open  = m_open();
        e.row   = m_row;
        e.hit   = e.open && (ra == m_row);
        e.cyc   = cyc;
        sb.push_back(e);
    endfunction

    task automatic step(input logic v, input logic [2:0] c, input logic [13:0] ra, output bit acc);
        @(negedge clk);
        rst_n = 1'b1;
        t_rcd_m1 = n_rcd; t_rp_m1 = n_rp; t_ras_m1 = n_ras;
        t_rfc_m1 = n_rfc; t_rtp_m1 = n_rtp; t_wtp_m1 = n_wtp;
        req_valid = v; req_cmd = c; req_ra = ra;
        push_exp(c, ra);
        acc = v && m_ready(c);
        if (acc) m_accept(c, ra);
        cyc++;
    endtask

    task automatic idle(input int n, input logic [13:0] ra);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 3'd2, ra, a);
    endtask

    task automatic hold(input logic [2:0] c, input logic [13:0] ra);
        bit a = 1'b0;
        int n = 0;
        while (!a && n < 64) begin
            step(1'b1, c, ra, a);
            n++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0; req_cmd = 3'd1; req_ra = 14'd0;
        m_reset();
        push_exp(3'd1, 14'd0);
        cyc++;
    endtask

    // Monitor: every cycle, once the combinational outputs have settled, check the prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks += 4;
                if (req_ready !== e.ready) begin
                    n_fail++;
                    $display("FAIL req_ready cyc=%0d actual=%b required=%b", e.cyc, req_ready, e.ready);
                end
                if (bank_open !== e.open) begin
                    n_fail++;
                    $display("FAIL bank_open cyc=%0d actual=%b required=%b", e.cyc, bank_open, e.open);
                end
                if (open_row !== e.row) begin
                    n_fail++;
                    $display("FAIL open_row cyc=%0d actual=%h required=%h", e.cyc, open_row, e.row);
                end
                if (row_hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL row_hit cyc=%0d actual=%b required=%b", e.cyc, row_hit, e.hit);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a;
        logic [2:0]  c;
        logic [13:0] ra;
        m_reset();

        // tRCD=2: RD held from cycle 1 goes through at cycle 3, row 0x1A5 then hits.
        n_rcd = 8'd2; n_ras = 8'd5; n_rtp = 8'd0; n_wtp = 8'd0; n_rp = 8'd1; n_rfc = 8'd9;
        hold(3'd1, 14'h1A5);
        hold(3'd2, 14'h1A5);
        idle(1, 14'h1A5);
        idle(1, 14'h1A4);
        hold(3'd4, 14'h1A5);
        idle(1, 14'h1A5);
        // tRP=1: ACT behind PRE waits two cycles.
        hold(3'd1, 14'h0033);
        idle(3, 14'h0033);
        hold(3'd4, 14'h0033);
        hold(3'd1, 14'h0077);
        idle(1, 14'h0077);

        // tRAS=2, tRTP=3: the RD-to-PRE window outlasts tRAS.
        hold(3'd4, 14'h0);
        n_rcd = 8'd1; n_ras = 8'd2; n_rtp = 8'd3;
        hold(3'd1, 14'h2222);
        idle(3, 14'h2222);
        hold(3'd2, 14'h2222);
        hold(3'd4, 14'h2222);
        // tRFC=9: ACT after REF waits ten cycles.
        hold(3'd5, 14'h0);
        hold(3'd1, 14'h0101);
        hold(3'd4, 14'h0101);
        hold(3'd5, 14'h0);
        idle(4, 14'h0);
        pulse_reset();
        hold(3'd1, 14'h0202);
        idle(2, 14'h0202);
        hold(3'd4, 14'h0202);
        idle(3, 14'h0);

        // Commands with no meaning in CLOSED, plus illegal opcodes.
        for (int i = 0; i < 20; i++) begin
            case (i % 6)
                0: c = 3'd2; 1: c = 3'd3; 2: c = 3'd4;
                3: c = 3'd0; 4: c = 3'd6; default: c = 3'd7;
            endcase
            step(1'b1, c, 14'h0, a);
        end

        // Random traffic with occasional timing changes and resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) begin
                n_rcd = 8'($urandom_range(0, 4)); n_ras = 8'($urandom_range(0, 8));
                n_rtp = 8'($urandom_range(0, 4)); n_wtp = 8'($urandom_range(0, 5));
                n_rp  = 8'($urandom_range(0, 3)); n_rfc = 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                c  = 3'($urandom_range(0, 7));
                ra = ($urandom_range(0, 1) == 0) ? m_row : 14'($urandom_range(0, 3));
                step($urandom_range(0, 3) != 0, c, ra, a);
            end
        end

        drv_done = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
